// File: rtl/sm4_req_sched_if.sv
// Bundle of requester, response and SM4-core signals seen by the request scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface sm4_req_sched_if;
  logic [1:0]   req_valid_i;
  logic [1:0]   req_ready_o;
  logic [1:0]   req_newkey_i;
  logic [1:0]   req_dec_i;
  logic [255:0] req_key_i;
  logic [255:0] req_data_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic         rsp_id_o;
  logic         rsp_err_o;
  logic [127:0] rsp_data_o;
  logic         core_sm4_enable_o;
  logic         core_encdec_enable_o;
  logic         core_encdec_sel_o;
  logic         core_valid_o;
  logic [127:0] core_data_o;
  logic         core_key_exp_o;
  logic         core_key_valid_o;
  logic [127:0] core_key_o;
  logic         core_key_ready_i;
  logic         core_valid_out_i;
  logic [127:0] core_result_i;

  modport master (
    input  req_valid_i, req_newkey_i, req_dec_i, req_key_i, req_data_i, rsp_ready_i,
    input  core_key_ready_i, core_valid_out_i, core_result_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o,
    output core_sm4_enable_o, core_encdec_enable_o, core_encdec_sel_o, core_valid_o,
    output core_data_o, core_key_exp_o, core_key_valid_o, core_key_o
  );

  modport slave (
    output req_valid_i, req_newkey_i, req_dec_i, req_key_i, req_data_i, rsp_ready_i,
    output core_key_ready_i, core_valid_out_i, core_result_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, rsp_data_o,
    input  core_sm4_enable_o, core_encdec_enable_o, core_encdec_sel_o, core_valid_o,
    input  core_data_o, core_key_exp_o, core_key_valid_o, core_key_o
  );
endinterface

// File: rtl/sm4_req_sched.sv
// Round-robin scheduler for two requesters sharing one SM4 core: caches the
// expanded key owner, sequences key expansion and block operation, with timeout.
module sm4_req_sched #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input logic              clk_i,
  input logic              rst_i,
  sm4_req_sched_if.master  bus
);
  typedef enum logic [2:0] {IDLE, KEY_LOAD, KEY_WAIT, DATA_ISSUE, DATA_WAIT, RESP} state_t;

  state_t           state_reg;
  logic             rr_ptr_reg;
  logic             key_owner_reg;
  logic             key_owner_vld_reg;
  logic             dec_reg;
  logic             id_reg;
  logic [127:0]     key_reg;
  logic [127:0]     data_reg;
  logic             rsp_valid_reg;
  logic             rsp_id_reg;
  logic             rsp_err_reg;
  logic [127:0]     rsp_data_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             any_valid;
  logic             grant;
  logic             cache_hit;
  logic             timeout;
  logic             active;
  logic [CNT_W-1:0] cnt_inc;
  logic [127:0]     key_sel;
  logic [127:0]     data_sel;

  always_comb begin
    any_valid = |bus.req_valid_i;
    // With a single requester it wins outright; contention falls back to the pointer.
    grant     = (&bus.req_valid_i) ? rr_ptr_reg : bus.req_valid_i[1];
    key_sel   = grant ? bus.req_key_i[255:128]  : bus.req_key_i[127:0];
    data_sel  = grant ? bus.req_data_i[255:128] : bus.req_data_i[127:0];
    cache_hit = key_owner_vld_reg && (key_owner_reg == grant) && !bus.req_newkey_i[grant];
    cnt_inc   = cnt_reg + 1'b1;
    timeout   = (cnt_inc == CNT_W'(TIMEOUT_CYC));
    active    = (state_reg != IDLE);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign bus.req_ready_o[gi] = (state_reg == IDLE) && any_valid && (grant == 1'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      rr_ptr_reg        <= 1'b0;
      key_owner_reg     <= 1'b0;
      key_owner_vld_reg <= 1'b0;
      dec_reg           <= 1'b0;
      id_reg            <= 1'b0;
      key_reg           <= '0;
      data_reg          <= '0;
      rsp_valid_reg     <= 1'b0;
      rsp_id_reg        <= 1'b0;
      rsp_err_reg       <= 1'b0;
      rsp_data_reg      <= '0;
      cnt_reg           <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            key_reg    <= key_sel;
            data_reg   <= data_sel;
            dec_reg    <= bus.req_dec_i[grant];
            id_reg     <= grant;
            rr_ptr_reg <= ~grant;
            state_reg  <= cache_hit ? DATA_ISSUE : KEY_LOAD;
          end
        end
        KEY_LOAD: begin
          key_owner_vld_reg <= 1'b0;
          cnt_reg           <= '0;
          state_reg         <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (bus.core_key_ready_i) begin
            key_owner_reg     <= id_reg;
            key_owner_vld_reg <= 1'b1;
            state_reg         <= DATA_ISSUE;
          end else if (timeout) begin
            rsp_valid_reg     <= 1'b1;
            rsp_id_reg        <= id_reg;
            rsp_err_reg       <= 1'b1;
            rsp_data_reg      <= '0;
            key_owner_vld_reg <= 1'b0;
            state_reg         <= RESP;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        DATA_ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= DATA_WAIT;
        end
        DATA_WAIT: begin
          // A result landing on the final counted cycle still completes normally.
          if (bus.core_valid_out_i) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= id_reg;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= bus.core_result_i;
            state_reg     <= RESP;
          end else if (timeout) begin
            rsp_valid_reg     <= 1'b1;
            rsp_id_reg        <= id_reg;
            rsp_err_reg       <= 1'b1;
            rsp_data_reg      <= '0;
            key_owner_vld_reg <= 1'b0;
            state_reg         <= RESP;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid_o          = rsp_valid_reg;
  assign bus.rsp_id_o             = rsp_id_reg;
  assign bus.rsp_err_o            = rsp_err_reg;
  assign bus.rsp_data_o           = rsp_data_reg;
  assign bus.core_sm4_enable_o    = active && (state_reg != RESP);
  assign bus.core_key_exp_o       = (state_reg == KEY_LOAD) || (state_reg == KEY_WAIT);
  assign bus.core_key_valid_o     = (state_reg == KEY_LOAD);
  assign bus.core_encdec_enable_o = (state_reg == DATA_ISSUE) || (state_reg == DATA_WAIT);
  assign bus.core_valid_o         = (state_reg == DATA_ISSUE);
  assign bus.core_encdec_sel_o    = active && dec_reg;
  assign bus.core_key_o           = active ? key_reg  : '0;
  assign bus.core_data_o          = active ? data_reg : '0;
endmodule
